reg_file: RTL

//   Integer register file for the basic RV32I core, with a busy scoreboard.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/reg_file.sv | 74 +++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core parameters.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    // Index of the hard-wired zero register x0.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : riscv_pkg

// File: rtl/reg_scoreboard.sv
// Busy vector for the integer register file. Each bit marks a register with a pending write.
module reg_scoreboard
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_idx,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_idx,
    input  logic [ADDR_W-1:0] i_rd1_idx,
    output logic              o_rd1_busy,
    input  logic [ADDR_W-1:0] i_rd2_idx,
    output logic              o_rd2_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Next busy vector: clear from write-back first, then set from issue.
    // A same-index set is applied last so a newer in-flight writer keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en && (i_clr_idx != REG_ZERO)) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en && (i_set_idx != REG_ZERO)) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
    end

    // Busy vector register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Lookup ports are not bypassed by a same-cycle write-back.
    always_comb begin
        o_rd1_busy = r_busy[i_rd1_idx];
        o_rd2_busy = r_busy[i_rd2_idx];
    end

endmodule : reg_scoreboard

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports with write-first bypass,
// one write-back port, and a per-register busy scoreboard.
module reg_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_ok;
    logic            w_issue_ok;

    // Qualify write-back and issue so x0 never takes data or a busy bit.
    always_comb begin
        w_wr_ok    = wr_en && (wr_addr != REG_ZERO);
        w_issue_ok = issue_valid && (issue_rd != REG_ZERO);
    end

    // Data array: asynchronous clear, one write per cycle from write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read muxes: same-cycle write-back forwarded first, x0 forced to zero.
    always_comb begin
        if (w_wr_ok && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end else if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else begin
            rs1_data = r_regs[rs1_addr];
        end

        if (w_wr_ok && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end else if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else begin
            rs2_data = r_regs[rs2_addr];
        end
    end

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_issue_ok),
        .i_set_idx  (issue_rd),
        .i_clr_en   (w_wr_ok),
        .i_clr_idx  (wr_addr),
        .i_rd1_idx  (rs1_addr),
        .o_rd1_busy (rs1_busy),
        .i_rd2_idx  (rs2_addr),
        .o_rd2_busy (rs2_busy)
    );

endmodule : reg_file
